// File: rtl/aes_pkg.sv
// Shared constants and types for the AES core arbiter: job modes, block width
// and the arbiter state encoding.
package aes_pkg;

  localparam logic MODE_ENC    = 1'b0;
  localparam logic MODE_DEC    = 1'b1;
  localparam int   AES_BLOCK_W = 128;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } arb_state_t;

  // A one-hot grant maps to the mode of the channel it selects.
  function automatic logic grant_mode(input logic [1:0] grant);
    return grant[1] ? MODE_DEC : MODE_ENC;
  endfunction

endpackage

// File: rtl/aes_core_arbiter_if.sv
// Signal bundle between the two request channels, the shared AES core and the
// response consumer. The arbiter uses the slave view, its environment the master view.
interface aes_core_arbiter_if
  import aes_pkg::*;
#(
  parameter int DATA_W = AES_BLOCK_W
);

  logic              enc_req_valid;
  logic              enc_req_ready;
  logic [DATA_W-1:0] enc_req_data;
  logic [DATA_W-1:0] enc_req_key;
  logic              dec_req_valid;
  logic              dec_req_ready;
  logic [DATA_W-1:0] dec_req_data;
  logic [DATA_W-1:0] dec_req_key;
  logic              core_start;
  logic              core_mode;
  logic [DATA_W-1:0] core_data;
  logic [DATA_W-1:0] core_key;
  logic              core_done;
  logic [DATA_W-1:0] core_result;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_tag;
  logic              rsp_err;
  logic              busy;

  modport slave (
    input  enc_req_valid, enc_req_data, enc_req_key,
           dec_req_valid, dec_req_data, dec_req_key,
           core_done, core_result, rsp_ready,
    output enc_req_ready, dec_req_ready,
           core_start, core_mode, core_data, core_key,
           rsp_valid, rsp_data, rsp_tag, rsp_err, busy
  );

  modport master (
    output enc_req_valid, enc_req_data, enc_req_key,
           dec_req_valid, dec_req_data, dec_req_key,
           core_done, core_result, rsp_ready,
    input  enc_req_ready, dec_req_ready,
           core_start, core_mode, core_data, core_key,
           rsp_valid, rsp_data, rsp_tag, rsp_err, busy
  );

endinterface

// File: rtl/aes_core_arbiter_rr.sv
// Two-request round-robin grant: a lone request wins outright, a contested
// pair goes to the channel that was not granted last.
module rr_arbiter2
  import aes_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // Pure combinational grant selection.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last_grant == MODE_DEC) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/aes_core_arbiter.sv
// Shares one iterative AES-128 core between an encrypt and a decrypt channel:
// round-robin job intake, core launch, watchdog-guarded wait, tagged response.
module aes_core_arbiter
  import aes_pkg::*;
#(
  parameter int DATA_W         = AES_BLOCK_W,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic               clk,
  input logic               reset,
  aes_core_arbiter_if.slave bus
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES);
  // Abort fires on the WAIT edge where the counter steps to TIMEOUT_CYCLES-1.
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 2);

  arb_state_t        state;
  logic              last_grant;
  logic [1:0]        grant;
  logic              enc_ready;
  logic              dec_ready;
  logic              start_pulse;
  logic              job_mode;
  logic [DATA_W-1:0] job_data;
  logic [DATA_W-1:0] job_key;
  logic [WD_W-1:0]   wdog;
  logic              rsp_pending;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_mode;
  logic              rsp_fault;
  logic              active;

  rr_arbiter2 u_rr (
    .req        ({bus.dec_req_valid, bus.enc_req_valid}),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // Ready is offered only to the granted channel, and only while idle.
  always_comb begin
    enc_ready = 1'b0;
    dec_ready = 1'b0;
    if (!reset && state == IDLE) begin
      enc_ready = grant[0];
      dec_ready = grant[1];
    end else begin
      enc_ready = 1'b0;
      dec_ready = 1'b0;
    end
  end

  // Job FSM with job registers, watchdog and registered response/core outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      last_grant  <= MODE_DEC;
      start_pulse <= 1'b0;
      job_mode    <= MODE_ENC;
      job_data    <= {DATA_W{1'b0}};
      job_key     <= {DATA_W{1'b0}};
      wdog        <= {WD_W{1'b0}};
      rsp_pending <= 1'b0;
      rsp_result  <= {DATA_W{1'b0}};
      rsp_mode    <= 1'b0;
      rsp_fault   <= 1'b0;
      active      <= 1'b0;
    end else begin
      start_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (grant != 2'b00) begin
            job_mode    <= grant_mode(grant);
            job_data    <= grant[1] ? bus.dec_req_data : bus.enc_req_data;
            job_key     <= grant[1] ? bus.dec_req_key  : bus.enc_req_key;
            last_grant  <= grant_mode(grant);
            start_pulse <= 1'b1;
            active      <= 1'b1;
            state       <= LAUNCH;
          end
        end
        LAUNCH: begin
          wdog  <= {WD_W{1'b0}};
          state <= WAIT;
        end
        WAIT: begin
          wdog <= wdog + WD_W'(1);
          if (bus.core_done) begin
            rsp_result  <= bus.core_result;
            rsp_fault   <= 1'b0;
            rsp_mode    <= job_mode;
            rsp_pending <= 1'b1;
            state       <= RESP;
          end else if (wdog == WD_LAST) begin
            rsp_result  <= {DATA_W{1'b0}};
            rsp_fault   <= 1'b1;
            rsp_mode    <= job_mode;
            rsp_pending <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_pending <= 1'b0;
            active      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          rsp_pending <= 1'b0;
          active      <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign bus.enc_req_ready = enc_ready;
  assign bus.dec_req_ready = dec_ready;
  assign bus.core_start    = start_pulse;
  assign bus.core_mode     = job_mode;
  assign bus.core_data     = job_data;
  assign bus.core_key      = job_key;
  assign bus.rsp_valid     = rsp_pending;
  assign bus.rsp_data      = rsp_result;
  assign bus.rsp_tag       = rsp_mode;
  assign bus.rsp_err       = rsp_fault;
  assign bus.busy          = active;

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Self-checking bench: directed job table, multi-cycle corner sequences and
// randomized jobs checked against a transaction-level arbitration/latency model.
module tb_aes_core_arbiter;

  localparam int TO = 64;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk;
  logic reset;

  aes_core_arbiter_if #(.DATA_W(128)) bus ();

  aes_core_arbiter #(.DATA_W(128), .TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit last_exp;          // model: mode granted last
  int core_lat  = 1;
  bit core_hang = 1'b0;
  int spur_req  = 0;

  typedef struct {
    bit           ev, dv;
    logic [127:0] ed, ek, dd, dk;
    int           lat;
    bit           hang;
    int           bp;
    bit           spur;
    bit           exp_tag, exp_err;
    logic [127:0] exp_data;
    int           exp_k;
  } vec_t;

  vec_t tv[9];

  // Behaviour of the fake AES core (stands in for the real round datapath).
  function automatic logic [127:0] core_fn(input logic m, input logic [127:0] d, input logic [127:0] k);
    if (m == 1'b0 && d == PT && k == KEY) return CT;
    return m ? (d ^ {k[63:0], k[127:64]}) : (d + k);
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Core model: done after core_lat cycles of core_start; spurious pulses on request.
  initial begin
    bit active;
    int cd;
    int spur_ack;
    active = 1'b0; cd = 0; spur_ack = 0;
    bus.core_done = 1'b0;
    bus.core_result = 128'h0;
    forever begin
      @(negedge clk);
      bus.core_done = 1'b0;
      bus.core_result = {$urandom, $urandom, $urandom, $urandom};
      if (reset) active = 1'b0;
      else if (active) begin
        cd--;
        if (cd == 0) begin
          bus.core_done = 1'b1;
          bus.core_result = core_fn(bus.core_mode, bus.core_data, bus.core_key);
          active = 1'b0;
        end
      end else if (bus.core_start && !core_hang) begin
        active = 1'b1;
        cd = core_lat;
      end
      if (spur_req != spur_ack) begin
        spur_ack++;
        bus.core_done = 1'b1;
      end
    end
  end

  // One complete job: offer, handshake, wait, optional backpressure, accept.
  task automatic run_job(input bit ev, input bit dv, input logic [127:0] ed, input logic [127:0] ek,
                         input logic [127:0] dd, input logic [127:0] dk, input int lat, input bit hang,
                         input int bp, input bit spur, output logic got_tag, output logic [127:0] got_data,
                         output logic got_err, output int got_k);
    bit m;
    int k, starts;
    bit seen, stable, bad_ready, oth;
    logic [127:0] hd;
    logic ht, he;
    m = (ev && dv) ? ~last_exp : dv;
    oth = m ? ev : dv;
    @(negedge clk);
    core_lat = lat; core_hang = hang;
    bus.enc_req_valid = ev; bus.enc_req_data = ed; bus.enc_req_key = ek;
    bus.dec_req_valid = dv; bus.dec_req_data = dd; bus.dec_req_key = dk;
    bus.rsp_ready = 1'b0;
    #1;
    chk("enc_ready_grant", bus.enc_req_ready, ev && !m);
    chk("dec_ready_grant", bus.dec_req_ready, dv && m);
    @(posedge clk);
    last_exp = m;
    k = 0; starts = 0; seen = 1'b0; bad_ready = 1'b0;
    while (!seen && k < 200) begin
      @(negedge clk);
      if (bus.core_start) starts++;
      if (bus.enc_req_ready || bus.dec_req_ready) bad_ready = 1'b1;
      if (k == 0) begin
        chk("launch_start", bus.core_start, 1'b1);
        chk("launch_mode", bus.core_mode, m);
        chk("launch_data", bus.core_data, m ? dd : ed);
        chk("launch_key", bus.core_key, m ? dk : ek);
        chk("launch_busy", bus.busy, 1'b1);
        if (m) bus.dec_req_valid = 1'b0; else bus.enc_req_valid = 1'b0;
      end
      if (bus.rsp_valid) seen = 1'b1;
      else begin
        @(posedge clk);
        k++;
      end
    end
    chk("rsp_within_bound", seen, 1'b1);
    chk("core_start_count", starts, 1);
    chk("mode_held", bus.core_mode, m);
    got_tag = bus.rsp_tag; got_data = bus.rsp_data; got_err = bus.rsp_err; got_k = k;
    hd = bus.rsp_data; ht = bus.rsp_tag; he = bus.rsp_err;
    stable = 1'b1;
    for (int i = 0; i < bp; i++) begin
      if (spur && i == 0) spur_req++;
      @(posedge clk);
      @(negedge clk);
      if (!bus.rsp_valid || bus.rsp_data !== hd || bus.rsp_tag !== ht || bus.rsp_err !== he) stable = 1'b0;
      if (bus.enc_req_ready || bus.dec_req_ready) bad_ready = 1'b1;
    end
    if (bp > 0) chk("rsp_hold_stable", stable, 1'b1);
    chk("ready_outside_idle", bad_ready, 1'b0);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rsp_valid_after_accept", bus.rsp_valid, 1'b0);
    chk("busy_after_accept", bus.busy, 1'b0);
    chk("other_ready_after_accept", m ? bus.enc_req_ready : bus.dec_req_ready, oth);
    bus.rsp_ready = 1'b0;
    bus.enc_req_valid = 1'b0;
    bus.dec_req_valid = 1'b0;
  endtask

  function automatic vec_t mk(input bit ev, input bit dv, input logic [127:0] ed, input logic [127:0] ek,
                              input logic [127:0] dd, input logic [127:0] dk, input int lat, input bit hang,
                              input int bp, input bit spur, input bit et, input bit ee,
                              input logic [127:0] edat, input int ekk);
    vec_t v;
    v.ev = ev; v.dv = dv; v.ed = ed; v.ek = ek; v.dd = dd; v.dk = dk;
    v.lat = lat; v.hang = hang; v.bp = bp; v.spur = spur;
    v.exp_tag = et; v.exp_err = ee; v.exp_data = edat; v.exp_k = ekk;
    return v;
  endfunction

  initial begin
    logic gt, ge;
    logic [127:0] gd;
    int gk;
    bit flag;
    logic [127:0] a, b, c, d;
    bit ev, dv, em, eerr;
    int lat, r, bp;
    bit hang;

    a = 128'hdeadbeef_01234567_89abcdef_cafef00d;
    b = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
    c = 128'h11111111_22222222_33333333_44444444;
    d = 128'h55555555_66666666_77777777_88888888;

    // Job table (after reset the encrypt channel wins the first contest).
    tv[0] = mk(1, 0, PT, KEY, c, d, 10, 0, 0, 0, 1'b0, 1'b0, CT, 11);
    tv[1] = mk(0, 1, c, d, a, b, 3, 0, 10, 1, 1'b1, 1'b0, core_fn(1'b1, a, b), 4);
    tv[2] = mk(1, 1, a, b, c, d, 1, 0, 0, 0, 1'b0, 1'b0, core_fn(1'b0, a, b), 2);
    tv[3] = mk(1, 1, a, b, c, d, 2, 0, 1, 0, 1'b1, 1'b0, core_fn(1'b1, c, d), 3);
    tv[4] = mk(1, 1, c, d, a, b, 5, 0, 0, 0, 1'b0, 1'b0, core_fn(1'b0, c, d), 6);
    tv[5] = mk(1, 1, c, d, a, b, 7, 0, 2, 0, 1'b1, 1'b0, core_fn(1'b1, a, b), 8);
    tv[6] = mk(1, 0, a, d, c, b, 1, 1, 0, 0, 1'b0, 1'b1, 128'h0, TO);
    tv[7] = mk(0, 1, a, d, c, b, TO - 1, 0, 0, 0, 1'b1, 1'b0, core_fn(1'b1, c, b), TO);
    tv[8] = mk(1, 0, b, c, a, d, TO, 0, 4, 0, 1'b0, 1'b1, 128'h0, TO);

    reset = 1'b1;
    bus.enc_req_valid = 1'b1; bus.dec_req_valid = 1'b1;
    bus.enc_req_data = a; bus.enc_req_key = b; bus.dec_req_data = c; bus.dec_req_key = d;
    bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_rsp_valid", bus.rsp_valid, 1'b0);
    chk("reset_core_start", bus.core_start, 1'b0);
    chk("reset_rsp_data", bus.rsp_data, 128'h0);
    chk("reset_ready", {bus.enc_req_ready, bus.dec_req_ready}, 2'b00);
    chk("reset_core_mode", bus.core_mode, 1'b0);
    bus.enc_req_valid = 1'b0; bus.dec_req_valid = 1'b0;
    reset = 1'b0;
    last_exp = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_job(tv[i].ev, tv[i].dv, tv[i].ed, tv[i].ek, tv[i].dd, tv[i].dk, tv[i].lat, tv[i].hang,
              tv[i].bp, tv[i].spur, gt, gd, ge, gk);
      chk($sformatf("vec%0d_tag", i), gt, tv[i].exp_tag);
      chk($sformatf("vec%0d_data", i), gd, tv[i].exp_data);
      chk($sformatf("vec%0d_err", i), ge, tv[i].exp_err);
      chk($sformatf("vec%0d_latency", i), gk, tv[i].exp_k);
    end

    // Spurious done while idle must not start a response.
    @(negedge clk);
    spur_req++;
    repeat (3) @(negedge clk);
    chk("idle_spur_busy", bus.busy, 1'b0);
    chk("idle_spur_rsp_valid", bus.rsp_valid, 1'b0);

    // Reset in the middle of WAIT drops the job; last grant returns to decrypt.
    run_job(0, 1, a, b, c, d, 2, 0, 0, 0, gt, gd, ge, gk);
    @(negedge clk);
    core_hang = 1'b1;
    bus.enc_req_valid = 1'b1; bus.enc_req_data = a; bus.enc_req_key = b;
    @(posedge clk);
    @(negedge clk);
    bus.enc_req_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_reset_busy", bus.busy, 1'b1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    last_exp = 1'b1;
    chk("midwait_reset_busy", bus.busy, 1'b0);
    chk("midwait_reset_rsp_valid", bus.rsp_valid, 1'b0);
    chk("midwait_reset_core_start", bus.core_start, 1'b0);
    flag = 1'b0;
    repeat (TO + 16) begin
      @(negedge clk);
      if (bus.rsp_valid || bus.busy) flag = 1'b1;
    end
    chk("no_rsp_after_reset", flag, 1'b0);
    run_job(1, 1, c, d, a, b, 4, 0, 0, 0, gt, gd, ge, gk);
    chk("post_reset_grant_tag", gt, 1'b0);
    chk("post_reset_data", gd, core_fn(1'b0, c, d));

    // Randomized jobs against the transaction model.
    for (int j = 0; j < 25; j++) begin
      r = $urandom_range(1, 3);
      ev = r[0]; dv = r[1];
      a = {$urandom, $urandom, $urandom, $urandom};
      b = {$urandom, $urandom, $urandom, $urandom};
      c = {$urandom, $urandom, $urandom, $urandom};
      d = {$urandom, $urandom, $urandom, $urandom};
      r = $urandom_range(0, 9);
      hang = (r == 0);
      lat = (r == 1) ? TO - 1 : (r == 2) ? TO : $urandom_range(1, 20);
      bp = $urandom_range(0, 4);
      em = (ev && dv) ? ~last_exp : dv;
      eerr = hang || (lat > TO - 1);
      run_job(ev, dv, a, b, c, d, lat, hang, bp, bp >= 3, gt, gd, ge, gk);
      chk($sformatf("rnd%0d_tag", j), gt, em);
      chk($sformatf("rnd%0d_err", j), ge, eerr);
      chk($sformatf("rnd%0d_data", j), gd, eerr ? 128'h0 : core_fn(em, em ? c : a, em ? d : b));
      chk($sformatf("rnd%0d_latency", j), gk, eerr ? TO : lat + 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
